// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single data-memory port: each access is a read phase, stores add a write phase.
// Optional macro DMEM_ARB_MISALIGN_CHK_EN answers misaligned requests with an error and no memory access.
module dmem_arbiter #(
    parameter int addrWidth  = 32,
    parameter int dataWidth  = 32,
    parameter bit strictPrio = 1'b0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 p0Valid,
    output logic                 p0Ready,
    input  logic [addrWidth-1:0] p0Addr,
    input  logic [2:0]           p0Op,
    input  logic                 p0We,
    input  logic [dataWidth-1:0] p0Wdata,
    output logic                 p0RspValid,
    output logic [dataWidth-1:0] p0RspData,
    output logic                 p0RspErr,
    input  logic                 p1Valid,
    output logic                 p1Ready,
    input  logic [addrWidth-1:0] p1Addr,
    input  logic [2:0]           p1Op,
    input  logic                 p1We,
    input  logic [dataWidth-1:0] p1Wdata,
    output logic                 p1RspValid,
    output logic [dataWidth-1:0] p1RspData,
    output logic                 p1RspErr,
    output logic [addrWidth-1:0] memAddr,
    output logic [dataWidth-1:0] memDin,
    output logic [2:0]           memOp,
    output logic                 memWe,
    output logic                 memRd,
    input  logic [dataWidth-1:0] memDout,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RSP = 2'd3} state_t;

    state_t               state_reg, state_next;
    logic                 rr_ptr_reg;
    logic                 port_reg;
    logic                 we_reg;
    logic                 err_reg;
    logic [addrWidth-1:0] addr_reg;
    logic [2:0]           op_reg;
    logic [dataWidth-1:0] wdata_reg;

    logic                 grant_valid;
    logic                 grant_port;
    logic [addrWidth-1:0] sel_addr;
    logic [2:0]           sel_op;
    logic                 sel_we;
    logic [dataWidth-1:0] sel_wdata;
    logic                 sel_err;
    logic [dataWidth-1:0] rsp_data;
    logic [1:0]           ready_vec;
    logic [1:0]           rsp_vec;

    // Reserved op codes collapse to a word access before they are latched.
    function automatic logic [2:0] norm_op(input logic [2:0] op);
        case (op)
            3'd0, 3'd1, 3'd2, 3'd4, 3'd5: norm_op = op;
            default:                      norm_op = 3'd2;
        endcase
    endfunction

    always_comb begin
        grant_valid = 1'b0;
        grant_port  = 1'b0;
        if (state_reg == IDLE) begin
            if (p0Valid && p1Valid) begin
                grant_valid = 1'b1;
                grant_port  = strictPrio ? 1'b0 : ~rr_ptr_reg;
            end else if (p0Valid) begin
                grant_valid = 1'b1;
            end else if (p1Valid) begin
                grant_valid = 1'b1;
                grant_port  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_addr  = grant_port ? p1Addr  : p0Addr;
        sel_op    = norm_op(grant_port ? p1Op : p0Op);
        sel_we    = grant_port ? p1We    : p0We;
        sel_wdata = grant_port ? p1Wdata : p0Wdata;
        sel_err   = 1'b0;
`ifdef DMEM_ARB_MISALIGN_CHK_EN
        case (sel_op)
            3'd1, 3'd5: sel_err = sel_addr[0];
            3'd2:       sel_err = |sel_addr[1:0];
            default:    sel_err = 1'b0;
        endcase
`endif
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= 1'b0;
            port_reg   <= 1'b0;
            we_reg     <= 1'b0;
            err_reg    <= 1'b0;
            addr_reg   <= '0;
            op_reg     <= '0;
            wdata_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (grant_valid) begin
                rr_ptr_reg <= grant_port;
                port_reg   <= grant_port;
                we_reg     <= sel_we;
                err_reg    <= sel_err;
                addr_reg   <= sel_addr;
                op_reg     <= sel_op;
                wdata_reg  <= sel_wdata;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_valid) state_next = sel_err ? RSP : RD;
            RD:      state_next = we_reg ? WR : RSP;
            WR:      state_next = RSP;
            RSP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign ready_vec[gi] = grant_valid && (grant_port == 1'(gi));
        assign rsp_vec[gi]   = (state_reg == RSP) && (port_reg == 1'(gi));
    end

    always_comb begin
        memRd   = (state_reg == RD);
        memWe   = (state_reg == WR);
        busy    = (state_reg != IDLE);
        memAddr = '0;
        memDin  = '0;
        memOp   = '0;
        if (state_reg != IDLE) begin
            memAddr = addr_reg;
            memDin  = wdata_reg;
            memOp   = op_reg;
        end
        // Stores and rejected requests return zero data.
        rsp_data   = (we_reg || err_reg) ? '0 : memDout;
        p0Ready    = ready_vec[0];
        p1Ready    = ready_vec[1];
        p0RspValid = rsp_vec[0];
        p1RspValid = rsp_vec[1];
        p0RspData  = rsp_vec[0] ? rsp_data : '0;
        p1RspData  = rsp_vec[1] ? rsp_data : '0;
        p0RspErr   = rsp_vec[0] && err_reg;
        p1RspErr   = rsp_vec[1] && err_reg;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: one round-robin instance and one strict-priority instance share stimulus.
`timescale 1ns/1ps
module tb_dmem_arbiter;
`ifdef DMEM_ARB_MISALIGN_CHK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr; logic [2:0] op; logic [2:0] exp_op; logic we;
        logic [31:0] wdata; logic [31:0] rdata; bit mis;
    } req_t;
    typedef struct { int cyc; logic we; logic [31:0] addr; logic [2:0] op; logic [31:0] din; } mem_t;
    typedef struct { int cyc; logic port; logic [31:0] data; logic err; } rsp_t;
    typedef struct { logic port; int gap; } gnt_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        p0Valid = 1'b0, p1Valid = 1'b0, p0We = 1'b0, p1We = 1'b0;
    logic [31:0] p0Addr = '0, p1Addr = '0, p0Wdata = '0, p1Wdata = '0;
    logic [2:0]  p0Op = '0, p1Op = '0;
    logic [31:0] memDout = '0;
    int          sel = 0;

    logic [1:0]  p0Ready_v, p1Ready_v, p0RspValid_v, p1RspValid_v, p0RspErr_v, p1RspErr_v;
    logic [1:0]  memWe_v, memRd_v, busy_v;
    logic [31:0] p0RspData_v [2];
    logic [31:0] p1RspData_v [2];
    logic [31:0] memAddr_v [2];
    logic [31:0] memDin_v [2];
    logic [2:0]  memOp_v [2];

    logic        p0Ready, p1Ready, p0RspValid, p1RspValid, p0RspErr, p1RspErr, memWe, memRd, busy;
    logic [31:0] p0RspData, p1RspData, memAddr, memDin;
    logic [2:0]  memOp;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        dmem_arbiter #(.addrWidth(32), .dataWidth(32), .strictPrio(gi == 1)) u_dut (
            .clk(clk), .rstn(rstn),
            .p0Valid(p0Valid), .p0Ready(p0Ready_v[gi]), .p0Addr(p0Addr), .p0Op(p0Op), .p0We(p0We),
            .p0Wdata(p0Wdata), .p0RspValid(p0RspValid_v[gi]), .p0RspData(p0RspData_v[gi]), .p0RspErr(p0RspErr_v[gi]),
            .p1Valid(p1Valid), .p1Ready(p1Ready_v[gi]), .p1Addr(p1Addr), .p1Op(p1Op), .p1We(p1We),
            .p1Wdata(p1Wdata), .p1RspValid(p1RspValid_v[gi]), .p1RspData(p1RspData_v[gi]), .p1RspErr(p1RspErr_v[gi]),
            .memAddr(memAddr_v[gi]), .memDin(memDin_v[gi]), .memOp(memOp_v[gi]), .memWe(memWe_v[gi]),
            .memRd(memRd_v[gi]), .memDout(memDout), .busy(busy_v[gi])
        );
    end

    assign p0Ready = p0Ready_v[sel];       assign p1Ready = p1Ready_v[sel];
    assign p0RspValid = p0RspValid_v[sel]; assign p1RspValid = p1RspValid_v[sel];
    assign p0RspErr = p0RspErr_v[sel];     assign p1RspErr = p1RspErr_v[sel];
    assign p0RspData = p0RspData_v[sel];   assign p1RspData = p1RspData_v[sel];
    assign memWe = memWe_v[sel];           assign memRd = memRd_v[sel];
    assign busy = busy_v[sel];             assign memAddr = memAddr_v[sel];
    assign memDin = memDin_v[sel];         assign memOp = memOp_v[sel];

    always #5 clk = ~clk;

    int          total = 0, bad = 0, cyc = 0;
    req_t        q0[$], q1[$];
    mem_t        mem_q[$];
    rsp_t        rsp_q[$];
    gnt_t        gnt_q[$];
    logic [31:0] cur_rdata = '0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (memRd) memDout <= cur_rdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add_req(input logic port, input logic [31:0] addr, input logic [2:0] op, input logic [2:0] exp_op,
                           input logic we, input logic [31:0] wdata, input logic [31:0] rdata, input bit mis);
        req_t r;
        r.addr = addr; r.op = op; r.exp_op = exp_op; r.we = we; r.wdata = wdata; r.rdata = rdata; r.mis = mis;
        if (port) q1.push_back(r); else q0.push_back(r);
    endtask

    task automatic add_gnt(input logic port, input int gap);
        gnt_t g;
        g.port = port; g.gap = gap;
        gnt_q.push_back(g);
    endtask

    task automatic push_expect(input logic port, input req_t r, input int t);
        mem_t m;
        rsp_t s;
        cur_rdata = r.rdata;
        s.port = port; s.err = 1'b0; s.data = '0;
        if (r.mis && MIS_EN) begin
            s.cyc = t + 1; s.err = 1'b1;
        end else begin
            m.cyc = t + 1; m.we = 1'b0; m.addr = r.addr; m.op = r.exp_op; m.din = r.wdata;
            mem_q.push_back(m);
            if (r.we) begin
                m.cyc = t + 2; m.we = 1'b1;
                mem_q.push_back(m);
                s.cyc = t + 3;
            end else begin
                s.cyc = t + 2; s.data = r.rdata;
            end
        end
        rsp_q.push_back(s);
    endtask

    task automatic drive_ports();
        p0Valid = (q0.size() > 0);
        p1Valid = (q1.size() > 0);
        if (q0.size() > 0) begin
            p0Addr = q0[0].addr; p0Op = q0[0].op; p0We = q0[0].we; p0Wdata = q0[0].wdata;
        end
        if (q1.size() > 0) begin
            p1Addr = q1[0].addr; p1Op = q1[0].op; p1We = q1[0].we; p1Wdata = q1[0].wdata;
        end
    endtask

    task automatic run_reqs(input int budget);
        int   n = 0;
        int   last_t = -1;
        bit   acc0, acc1;
        logic port;
        req_t r;
        gnt_t g;
        @(posedge clk); #1;
        drive_ports();
        while ((q0.size() + q1.size() + mem_q.size() + rsp_q.size()) > 0 && n < budget) begin
            @(negedge clk);
            acc0 = p0Valid && p0Ready;
            acc1 = p1Valid && p1Ready;
            if (acc0 || acc1) begin
                chk("single_ready", {acc1, acc0} == 2'b11, 1'b0);
                port = acc0 ? 1'b0 : 1'b1;
                r = port ? q1[0] : q0[0];
                if (gnt_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL grant_unexpected: got port %0d want no grant", port);
                end else begin
                    g = gnt_q.pop_front();
                    chk("grant_port", port, g.port);
                    if (g.gap > 0) chk("grant_gap", cyc - last_t, g.gap);
                end
                last_t = cyc;
                push_expect(port, r, cyc);
            end
            @(posedge clk); #1;
            if (acc0) void'(q0.pop_front());
            else if (acc1) void'(q1.pop_front());
            drive_ports();
            n++;
        end
        if (n >= budget) begin
            total++; bad++;
            $display("FAIL run_timeout: got %0d cycles want completion", n);
            q0.delete(); q1.delete(); mem_q.delete(); rsp_q.delete(); gnt_q.delete();
            drive_ports();
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0; p0Valid = 1'b0; p1Valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever the selected DUT drives the memory or a response.
    initial begin
        mem_t m;
        rsp_t s;
        forever begin
            @(negedge clk);
            if (memRd || memWe) begin
                if (mem_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL mem_unexpected: got rd=%0b we=%0b addr=0x%0h want no access", memRd, memWe, memAddr);
                end else begin
                    m = mem_q.pop_front();
                    chk("mem_cycle", cyc, m.cyc);
                    chk("mem_rd_we", {memRd, memWe}, {~m.we, m.we});
                    chk("mem_addr", memAddr, m.addr);
                    chk("mem_op", memOp, m.op);
                    chk("mem_din", memDin, m.din);
                end
            end
            if (p0RspValid || p1RspValid) begin
                if (rsp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rsp_unexpected: got p0=%0b p1=%0b want no response", p0RspValid, p1RspValid);
                end else begin
                    s = rsp_q.pop_front();
                    chk("rsp_port", {p1RspValid, p0RspValid}, s.port ? 2'b10 : 2'b01);
                    chk("rsp_cycle", cyc, s.cyc);
                    chk("rsp_data", s.port ? p1RspData : p0RspData, s.data);
                    chk("rsp_err", s.port ? p1RspErr : p0RspErr, s.err);
                    $display("rsp port=%0d cycle=%0d data=0x%08h err=%0b", s.port, cyc,
                             s.port ? p1RspData : p0RspData, s.port ? p1RspErr : p0RspErr);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        req_t ra;
        int   t;
        do_reset();
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_rd_we", {memRd, memWe}, 2'b00);
        chk("rst_ready", {p1Ready, p0Ready}, 2'b00);
        chk("rst_rsp", {p1RspValid, p0RspValid, p1RspErr, p0RspErr}, 4'b0);
        chk("rst_mem_addr", memAddr, 32'h0);

        // Store aborted by reset during its write phase.
        @(posedge clk); #1;
        p0Valid = 1'b1; p0Addr = 32'h10; p0Op = 3'd2; p0We = 1'b1; p0Wdata = 32'h5555AAAA;
        @(negedge clk);
        chk("abort_ready", p0Ready, 1'b1);
        t = cyc;
        ra.addr = 32'h10; ra.op = 3'd2; ra.exp_op = 3'd2; ra.we = 1'b1; ra.wdata = 32'h5555AAAA; ra.rdata = '0; ra.mis = 0;
        push_expect(1'b0, ra, t);
        void'(rsp_q.pop_back());
        @(posedge clk); #1 p0Valid = 1'b0;
        @(posedge clk); #1 rstn = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        @(negedge clk);
        chk("abort_memwe", memWe, 1'b0);
        chk("abort_busy", busy, 1'b0);
        repeat (4) @(negedge clk);
        chk("abort_no_rsp", {p1RspValid, p0RspValid}, 2'b00);

        add_req(0, 32'h100, 3'd2, 3'd2, 0, 32'h0, 32'hDEADBEEF, 0); add_gnt(0, 0);
        run_reqs(40);
        add_req(1, 32'h203, 3'd0, 3'd0, 1, 32'hAB, 32'h0, 0); add_gnt(1, 0);
        run_reqs(40);

        // Both ports streaming loads after a port-1 grant: alternate starting with port 0.
        add_req(0, 32'h300, 3'd2, 3'd2, 0, 32'h0, 32'h11111111, 0);
        add_req(0, 32'h304, 3'd2, 3'd2, 0, 32'h0, 32'h33333333, 0);
        add_req(1, 32'h400, 3'd2, 3'd2, 0, 32'h0, 32'h22222222, 0);
        add_req(1, 32'h404, 3'd2, 3'd2, 0, 32'h0, 32'h44444444, 0);
        add_gnt(0, 0); add_gnt(1, 3); add_gnt(0, 3); add_gnt(1, 3);
        run_reqs(80);

        add_req(0, 32'h101, 3'd1, 3'd1, 0, 32'h0, 32'h00001234, 1); add_gnt(0, 0);
        run_reqs(40);
        add_req(1, 32'h202, 3'd2, 3'd2, 1, 32'hCAFEF00D, 32'h0, 1); add_gnt(1, 0);
        run_reqs(40);
        add_req(1, 32'h40, 3'd7, 3'd2, 0, 32'h0, 32'h00000077, 0); add_gnt(1, 0);
        run_reqs(40);
        add_req(0, 32'h22, 3'd1, 3'd1, 1, 32'hBEEF, 32'h0, 0); add_gnt(0, 0);
        run_reqs(40);

        // Competing stores after a port-0 grant: port 1 first, next accept four cycles later.
        add_req(0, 32'h51, 3'd0, 3'd0, 1, 32'h12, 32'h0, 0);
        add_req(1, 32'h60, 3'd2, 3'd2, 1, 32'h9ABCDEF0, 32'h0, 0);
        add_gnt(1, 0); add_gnt(0, 4);
        run_reqs(80);

        // Strict-priority instance: port 1 waits until port 0 runs dry.
        do_reset();
        sel = 1;
        add_req(0, 32'h500, 3'd2, 3'd2, 0, 32'h0, 32'hA0A0A0A0, 0);
        add_req(0, 32'h504, 3'd4, 3'd4, 0, 32'h0, 32'hB1B1B1B1, 0);
        add_req(0, 32'h508, 3'd5, 3'd5, 0, 32'h0, 32'hC2C2C2C2, 0);
        add_req(1, 32'h600, 3'd2, 3'd2, 0, 32'h0, 32'hD3D3D3D3, 0);
        add_gnt(0, 0); add_gnt(0, 3); add_gnt(0, 3); add_gnt(1, 3);
        run_reqs(80);

        repeat (3) @(negedge clk);
        chk("sb_empty", mem_q.size() + rsp_q.size() + gnt_q.size(), 0);
        chk("end_busy", busy, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
